// File: rtl/vending_pkg.sv
// Shared vending definitions: coin codes and coin acceptor FSM encodings.
// Imported by the coin acceptor and by the downstream vending FSM.
package vending_pkg;

    typedef enum logic [1:0] {
        COIN_NONE   = 2'b00,
        COIN_NICKEL = 2'b01,
        COIN_DIME   = 2'b10
    } coin_e;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StEmit,
        StReject,
        StRelease
    } coin_state_e;

    localparam int unsigned CntWidth = 4;

    // Increment that sticks at lim instead of wrapping.
    function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v,
                                                    input logic [CntWidth-1:0] lim);
        return (v >= lim) ? lim : v + 4'd1;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level, cleared by reset.
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/coin_acceptor.sv
// Debounces the nickel/dime slot sensors and emits one coin code per insertion,
// rejecting simultaneous or overlapping sensor activity.
module coin_acceptor
    import vending_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       nickel_in,
    input  logic       dime_in,
    input  logic       hold,
    output logic [1:0] coin,
    output logic       reject
);

    localparam logic [CntWidth-1:0] DebLim = CntWidth'(DEBOUNCE_CYCLES);

    logic s_n;
    logic s_d;

    sync2 u_sync_nickel (
        .clk   (clk),
        .reset (reset),
        .d     (nickel_in),
        .q     (s_n)
    );

    sync2 u_sync_dime (
        .clk   (clk),
        .reset (reset),
        .d     (dime_in),
        .q     (s_d)
    );

    coin_state_e         state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    coin_e               type_q, type_d;

    // Reset lands in release so a coin sitting in the slot is not counted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StRelease;
            cnt_q   <= '0;
            type_q  <= COIN_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            type_q  <= type_d;
        end
    end

    logic own_s;
    logic other_s;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        type_d  = type_q;
        coin    = COIN_NONE;
        reject  = 1'b0;
        own_s   = (type_q == COIN_DIME) ? s_d : s_n;
        other_s = (type_q == COIN_DIME) ? s_n : s_d;

        unique case (state_q)
            StIdle: begin
                if (s_n && s_d) begin
                    state_d = StReject;
                end else if (s_n) begin
                    state_d = StSettle;
                    cnt_d   = 4'd1;
                    type_d  = COIN_NICKEL;
                end else if (s_d) begin
                    state_d = StSettle;
                    cnt_d   = 4'd1;
                    type_d  = COIN_DIME;
                end
            end
            StSettle: begin
                // The other sensor wins over the count: a mixed sample is never a coin.
                if (other_s) begin
                    state_d = StReject;
                end else if (!own_s) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q, DebLim);
                    if (cnt_d == DebLim) begin
                        state_d = StEmit;
                    end
                end
            end
            StEmit: begin
                if (!hold) begin
                    coin    = type_q;
                    state_d = StRelease;
                    cnt_d   = '0;
                end
            end
            StReject: begin
                reject  = 1'b1;
                state_d = StRelease;
                cnt_d   = '0;
            end
            StRelease: begin
                if (s_n || s_d) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q, DebLim);
                    if (cnt_d == DebLim) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        type_d  = COIN_NONE;
                    end
                end
            end
            default: begin
                state_d = StRelease;
                cnt_d   = '0;
                type_d  = COIN_NONE;
            end
        endcase
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed, table-driven bench for coin_acceptor with DEBOUNCE_CYCLES = 4.
module tb_coin_acceptor;

    logic       clk = 1'b0;
    logic       reset;
    logic       nickel_in;
    logic       dime_in;
    logic       hold;
    logic [1:0] coin;
    logic       reject;

    int checks = 0;
    int passes = 0;

    typedef struct packed {
        logic       n;
        logic       d;
        logic       h;
        logic [1:0] c;
        logic       r;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    coin_acceptor #(.DEBOUNCE_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .nickel_in (nickel_in),
        .dime_in   (dime_in),
        .hold      (hold),
        .coin      (coin),
        .reject    (reject)
    );

    task automatic check(input string name, input int idx, input logic [1:0] act,
                         input logic [1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s[%0d]: got %0b, expected %0b", name, idx, act, exp);
    endtask

    // Vector k is driven just after the falling edge preceding rising edge k.
    task automatic drive(input logic n, input logic d, input logic h);
        @(negedge clk);
        nickel_in = n;
        dime_in   = d;
        hold      = h;
        #1;
    endtask

    task automatic add(input logic n, input logic d, input logic h, input logic [1:0] c,
                       input logic r);
        vecs.push_back({n, d, h, c, r});
    endtask

    task automatic run(input string name);
        foreach (vecs[i]) begin
            drive(vecs[i].n, vecs[i].d, vecs[i].h);
            check({name, "_coin"}, i, coin, vecs[i].c);
            check({name, "_reject"}, i, {1'b0, reject}, {1'b0, vecs[i].r});
        end
        vecs.delete();
    endtask

    initial begin
        reset     = 1'b0;
        nickel_in = 1'b0;
        dime_in   = 1'b0;
        hold      = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_coin", 0, coin, 2'b00);
        check("reset_reject", 0, {1'b0, reject}, 2'b00);

        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) add(0, 0, 0, 2'b00, 0);
        run("post_reset");

        // Nickel held 12 cycles: single 01 pulse in vector 6.
        for (int i = 0; i < 20; i++)
            add(i < 12, 0, 0, (i == 6) ? 2'b01 : 2'b00, 0);
        run("nickel");

        // 2-cycle dime glitch discarded; a nickel right after proves IDLE was reached.
        for (int i = 0; i < 16; i++)
            add(i >= 3 && i <= 8, i < 2, 0, (i == 9) ? 2'b01 : 2'b00, 0);
        run("dime_glitch");

        // Dime arrives during nickel settle: one reject pulse, no coin.
        for (int i = 0; i < 14; i++)
            add(i <= 5, i == 2 || i == 3, 0, 2'b00, i == 5);
        run("overlap_reject");

        // Dime debounced while hold is high for 3 cycles: emitted after hold drops.
        for (int i = 0; i < 18; i++)
            add(0, i <= 9, i >= 6 && i <= 8, (i == 9) ? 2'b10 : 2'b00, 0);
        run("dime_hold");

        // Bounce during release after a dime; nickel timed to hit the first IDLE cycle.
        for (int i = 0; i < 30; i++)
            add(i >= 14 && i <= 21, i <= 6 || i == 9, 0,
                (i == 6) ? 2'b10 : (i == 20) ? 2'b01 : 2'b00, 0);
        run("release_bounce");

        // Reset mid-SETTLE with nickel held.
        for (int i = 0; i < 4; i++) drive(1, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_settle_coin", 0, coin, 2'b00);
        check("rst_settle_reject", 0, {1'b0, reject}, 2'b00);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 34; i++)
            add(i < 12 || (i >= 18 && i <= 25), 0, 0, (i == 24) ? 2'b01 : 2'b00, 0);
        run("rst_settle_after");

        // Reset while a dime waits in EMIT under hold: the dime is discarded.
        for (int i = 0; i < 6; i++) drive(0, 1, 0);
        drive(0, 1, 1);
        check("emit_held_coin", 0, coin, 2'b00);
        reset = 1'b0;
        #1;
        check("rst_emit_coin", 0, coin, 2'b00);
        check("rst_emit_reject", 0, {1'b0, reject}, 2'b00);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 12; i++) add(0, 0, 0, 2'b00, 0);
        run("rst_emit_after");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
